fifo_to_mem_mq: RTL and testbench
=================================

FIFO_TO_MEM_MQ -- requirements
Module: fifo_to_mem_mq

Interface
REQ-001 Parameter NUM_QUEUES, default 4: number of queues; any value >= 1.
REQ-002 Parameter NUM_QUEUES_BITS, default log2(NUM_QUEUES) (minimum 1): queue-ID width.
REQ-003 Parameter FIFO_DATA_WIDTH, default 144: FIFO word width; must equal 2*MEM_DATA_WIDTH.
REQ-004 Parameters MEM_ADDR_WIDTH / MEM_DATA_WIDTH / MEM_BW_WIDTH, defaults 19 / 72 / 8: memory address, data-half and byte-write widths.
REQ-005 Parameter CNT_WIDTH, default 32: statistics counter width.
REQ-006 Port clk, input, 1: sole clock. Port rst_n, input, 1: synchronous, active-low reset.
REQ-007 Ports fifo_rd_en out 1 / fifo_data in FIFO_DATA_WIDTH / fifo_qid in NUM_QUEUES_BITS / fifo_empty in 1: first-word-fall-through FIFO read side.
REQ-008 Ports mem_wr_full in 1 / mem_ad_w_n out 1 / mem_d_w_n out 1 / mem_ad_wr out MEM_ADDR_WIDTH / mem_dwl, mem_dwh out MEM_DATA_WIDTH each / mem_bwl_n, mem_bwh_n out MEM_BW_WIDTH each: memory write port.
REQ-009 Ports q_addr_low, q_addr_high in NUM_QUEUES*MEM_ADDR_WIDTH: packed per-queue region bounds, queue i in slice i; high is exclusive.
REQ-010 Ports q_enable in NUM_QUEUES / q_wrap in NUM_QUEUES: per-queue enable and ring-mode select.
REQ-011 Ports sw_rst in 1 / cal_done in 1: software reset, memory calibration done.
REQ-012 Ports q_full out NUM_QUEUES / q_wrapped out NUM_QUEUES: sticky region-full and has-wrapped flags.
REQ-013 Ports q_wr_cnt, q_drop_cnt out NUM_QUEUES*CNT_WIDTH: per-queue written and dropped beat counts (present only per REQ-034).

Function
REQ-014 FSM states: INIT (wait cal_done), IDLE (no queue enabled), RUN; INIT->IDLE on cal_done=1; IDLE->RUN when |q_enable; RUN->IDLE when q_enable==0 and beat pair complete; any state->INIT on cal_done=0.
REQ-015 fifo_rd_en SHALL be combinational: !fifo_empty && !mem_wr_full && state in {IDLE,RUN}; IDLE reads discard data.
REQ-016 Each queue keeps a beat pointer of MEM_ADDR_WIDTH+1 bits; mem_ad_wr = pointer[MEM_ADDR_WIDTH:1], two beats per address.
REQ-017 A beat consumed in RUN with queue qid enabled and !q_full[qid] SHALL be written: one cycle later mem_ad_w_n=mem_d_w_n=0, mem_dwl=fifo_data low half, mem_dwh=high half, mem_ad_wr=pre-increment pointer address.
REQ-018 Cycles without a written beat SHALL drive mem_ad_w_n=mem_d_w_n=1; mem_bwl_n/mem_bwh_n tie to all zeros.
REQ-019 Pointer advance: pointer==({high,0}-1) after a written beat -> if q_wrap[i] pointer={low,0} and q_wrapped[i]<=1, else q_full[i]<=1 and pointer holds; otherwise pointer+1.
REQ-020 Beats for a disabled or full queue SHALL be consumed and discarded (counted as drops).
REQ-021 qid_out of range (>= NUM_QUEUES) SHALL be consumed, discarded, no counter change.
REQ-022 Disabling queue i (q_enable[i] 1->0) SHALL reload pointer i to {low,0} and clear q_full[i], q_wrapped[i] next cycle.
REQ-023 mem_wr_full asserted stalls reads; no beat lost, no write strobe during stall.
REQ-024 cal_done deasserted mid-run SHALL stop reads immediately; pointers retained.

Reset
REQ-025 rst_n==0 or registered sw_rst==1 at clk edge: state=INIT, mem_ad_w_n=mem_d_w_n=1, mem_ad_wr=0, mem_dwl=mem_dwh=0.
REQ-026 Same reset: pointer i={q_addr_low[i],0}, q_full=0, q_wrapped=0, all counters 0.
REQ-027 sw_rst SHALL be registered one cycle before taking effect; reset mid-write discards any pending beat.

Configuration
REQ-034 Macro FIFO_TO_MEM_MQ_STATS_EN defined: q_wr_cnt/q_drop_cnt SHALL count per queue, saturating at all-ones, reset per REQ-026.
REQ-035 Macro undefined: q_wr_cnt/q_drop_cnt SHALL be driven constant 0 and no counter logic synthesised.

Verification
REQ-040 Queue 0 low=0x100 high=0x102, wrap=0, 6 beats qid 0 -> writes at 0x100,0x100,0x101,0x101; q_full[0]=1; 2 drops.
REQ-041 Same with wrap=1 -> addresses 0x100,0x100,0x101,0x101,0x100,0x100; q_wrapped[0]=1; q_full[0]=0.
REQ-042 Interleaved qid 1,2,1 with distinct bounds -> each write at its own queue's pointer; pointers independent.
REQ-043 mem_wr_full held 5 cycles mid-stream -> fifo_rd_en=0, no strobes, resume without loss or duplication.
REQ-044 sw_rst pulse mid-stream -> after 2 cycles strobes high, pointers at low, counters 0, state INIT then IDLE/RUN.
REQ-045 Build without FIFO_TO_MEM_MQ_STATS_EN, run REQ-040 -> identical memory writes, counters read 0.

Source files
------------

// File: rtl/fifo_to_mem_mq.sv
// rtl/fifo_to_mem_mq.sv - multi-queue FIFO drain into per-queue memory regions (stats: FIFO_TO_MEM_MQ_STATS_EN)
module fifo_to_mem_mq #(
  parameter int NUM_QUEUES      = 4,
  parameter int NUM_QUEUES_BITS = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  parameter int FIFO_DATA_WIDTH = 144,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 72,
  parameter int MEM_BW_WIDTH    = 8,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               fifo_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0]         fifo_data,
  input  logic [NUM_QUEUES_BITS-1:0]         fifo_qid,
  input  logic                               fifo_empty,
  input  logic                               mem_wr_full,
  output logic                               mem_ad_w_n,
  output logic                               mem_d_w_n,
  output logic [MEM_ADDR_WIDTH-1:0]          mem_ad_wr,
  output logic [MEM_DATA_WIDTH-1:0]          mem_dwl,
  output logic [MEM_DATA_WIDTH-1:0]          mem_dwh,
  output logic [MEM_BW_WIDTH-1:0]            mem_bwl_n,
  output logic [MEM_BW_WIDTH-1:0]            mem_bwh_n,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_low,
  input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_high,
  input  logic [NUM_QUEUES-1:0]              q_enable,
  input  logic [NUM_QUEUES-1:0]              q_wrap,
  input  logic                               sw_rst,
  input  logic                               cal_done,
  output logic [NUM_QUEUES-1:0]              q_full,
  output logic [NUM_QUEUES-1:0]              q_wrapped,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]    q_wr_cnt,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]    q_drop_cnt
);

  typedef enum logic [1:0] {INIT, IDLE, RUN} state_t;

  state_t                  state, state_next;
  logic                    sw_rst_q;
  logic                    rst;
  logic                    qid_ok;
  logic                    wr_beat;
  logic [NUM_QUEUES-1:0]   q_enable_q;
  logic [MEM_ADDR_WIDTH:0] ptr      [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH:0] low_beat [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH:0] ptr_last [NUM_QUEUES];

  assign rst = !rst_n || sw_rst_q;

  // cal_done gates the read directly so a calibration loss stops reads in the same cycle
  assign fifo_rd_en = !fifo_empty && !mem_wr_full && cal_done && (state == IDLE || state == RUN);
  assign qid_ok     = int'(fifo_qid) < NUM_QUEUES;
  assign wr_beat    = fifo_rd_en && (state == RUN) && qid_ok && q_enable[fifo_qid] && !q_full[fifo_qid];

  assign mem_bwl_n = '0;
  assign mem_bwh_n = '0;

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_bounds
    assign low_beat[g] = {q_addr_low[g*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH], 1'b0};
    assign ptr_last[g] = {q_addr_high[g*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH], 1'b0} - (MEM_ADDR_WIDTH+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sw_rst_q <= 1'b0;
    else        sw_rst_q <= sw_rst;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!cal_done) begin
      state_next = INIT;
    end else begin
      case (state)
        INIT:    state_next = IDLE;
        IDLE:    if (|q_enable) state_next = RUN;
        RUN:     if (q_enable == '0 && mem_d_w_n) state_next = IDLE;
        default: state_next = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ad_w_n <= 1'b1;
      mem_d_w_n  <= 1'b1;
      mem_ad_wr  <= '0;
      mem_dwl    <= '0;
      mem_dwh    <= '0;
      q_full     <= '0;
      q_wrapped  <= '0;
      q_enable_q <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) ptr[i] <= low_beat[i];
    end else begin
      mem_ad_w_n <= !wr_beat;
      mem_d_w_n  <= !wr_beat;
      q_enable_q <= q_enable;
      if (wr_beat) begin
        mem_ad_wr <= ptr[fifo_qid][MEM_ADDR_WIDTH:1];
        mem_dwl   <= fifo_data[MEM_DATA_WIDTH-1:0];
        mem_dwh   <= fifo_data[FIFO_DATA_WIDTH-1:MEM_DATA_WIDTH];
      end
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (q_enable_q[i] && !q_enable[i]) begin
          ptr[i]       <= low_beat[i];
          q_full[i]    <= 1'b0;
          q_wrapped[i] <= 1'b0;
        end else if (wr_beat && int'(fifo_qid) == i) begin
          // A full queue keeps its pointer parked on the last beat
          if (ptr[i] == ptr_last[i]) begin
            if (q_wrap[i]) begin
              ptr[i]       <= low_beat[i];
              q_wrapped[i] <= 1'b1;
            end else begin
              q_full[i] <= 1'b1;
            end
          end else begin
            ptr[i] <= ptr[i] + (MEM_ADDR_WIDTH+1)'(1);
          end
        end
      end
    end
  end

`ifdef FIFO_TO_MEM_MQ_STATS_EN
  logic                 drop_beat;
  logic [CNT_WIDTH-1:0] wr_cnt   [NUM_QUEUES];
  logic [CNT_WIDTH-1:0] drop_cnt [NUM_QUEUES];

  assign drop_beat = fifo_rd_en && qid_ok && !wr_beat;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (rst) begin
        wr_cnt[i]   <= '0;
        drop_cnt[i] <= '0;
      end else if (int'(fifo_qid) == i) begin
        if (wr_beat && wr_cnt[i] != '1)     wr_cnt[i]   <= wr_cnt[i] + CNT_WIDTH'(1);
        if (drop_beat && drop_cnt[i] != '1) drop_cnt[i] <= drop_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
    assign q_wr_cnt[g*CNT_WIDTH +: CNT_WIDTH]   = wr_cnt[g];
    assign q_drop_cnt[g*CNT_WIDTH +: CNT_WIDTH] = drop_cnt[g];
  end
`else
  assign q_wr_cnt   = '0;
  assign q_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_to_mem_mq.sv
// tb/tb_fifo_to_mem_mq.sv - randomized self-checking bench for fifo_to_mem_mq with a region-offset reference model
module tb_fifo_to_mem_mq;
  localparam int NQ  = 3;
  localparam int QB  = 2;
  localparam int MAW = 19;
  localparam int MDW = 72;
  localparam int FDW = 144;
  localparam int BW  = 8;
  localparam int CW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, fifo_rd_en, fifo_empty = 1'b1, mem_wr_full = 1'b0;
  logic mem_ad_w_n, mem_d_w_n, sw_rst = 1'b0, cal_done = 1'b1;
  logic [FDW-1:0] fifo_data = '0;
  logic [QB-1:0]  fifo_qid = '0;
  logic [MAW-1:0] mem_ad_wr;
  logic [MDW-1:0] mem_dwl, mem_dwh;
  logic [BW-1:0]  mem_bwl_n, mem_bwh_n;
  logic [NQ*MAW-1:0] q_addr_low = '0, q_addr_high = '0;
  logic [NQ-1:0] q_enable = '0, q_wrap = '0, q_full, q_wrapped;
  logic [NQ*CW-1:0] q_wr_cnt, q_drop_cnt;

  fifo_to_mem_mq #(.NUM_QUEUES(NQ), .NUM_QUEUES_BITS(QB), .FIFO_DATA_WIDTH(FDW),
    .MEM_ADDR_WIDTH(MAW), .MEM_DATA_WIDTH(MDW), .MEM_BW_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_qid(fifo_qid),
    .fifo_empty(fifo_empty), .mem_wr_full(mem_wr_full), .mem_ad_w_n(mem_ad_w_n), .mem_d_w_n(mem_d_w_n),
    .mem_ad_wr(mem_ad_wr), .mem_dwl(mem_dwl), .mem_dwh(mem_dwh), .mem_bwl_n(mem_bwl_n), .mem_bwh_n(mem_bwh_n),
    .q_addr_low(q_addr_low), .q_addr_high(q_addr_high), .q_enable(q_enable), .q_wrap(q_wrap),
    .sw_rst(sw_rst), .cal_done(cal_done), .q_full(q_full), .q_wrapped(q_wrapped),
    .q_wr_cnt(q_wr_cnt), .q_drop_cnt(q_drop_cnt));

  typedef struct { logic [FDW-1:0] d; int q; } beat_t;

  int n_cmp = 0, n_bad = 0;
  beat_t fq[$];
  int waddr[$];
  // Model: a queue is its region [lo,hi) seen as a beat offset from the region start
  int lo[NQ], hi[NQ], off[NQ];
  bit full[NQ], wrapd[NQ];
  longint wr[NQ], dr[NQ];
  bit exp_wr, exp_rst;
  int exp_addr, hold = 0, gap_pct = 0, full_pct = 0, stall = 0;
  logic [FDW-1:0] exp_data;

  task automatic chk(input string name, input logic [FDW-1:0] act, input logic [FDW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FDW-1:0] rand_data();
    logic [159:0] t;
    for (int w = 0; w < 5; w++) t[w*32 +: 32] = $urandom;
    return t[FDW-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) begin
      off[i] = 0; full[i] = 0; wrapd[i] = 0; wr[i] = 0; dr[i] = 0;
    end
  endtask

  task automatic set_bounds(input int i, input int l, input int h);
    lo[i] = l; hi[i] = h;
    q_addr_low[i*MAW +: MAW]  = MAW'(l);
    q_addr_high[i*MAW +: MAW] = MAW'(h);
  endtask

  task automatic set_enable(input logic [NQ-1:0] en);
    for (int i = 0; i < NQ; i++)
      if (q_enable[i] && !en[i]) begin off[i] = 0; full[i] = 0; wrapd[i] = 0; end
    q_enable = en;
    hold = 3;
  endtask

  task automatic consume(input beat_t b);
    if (b.q >= NQ) return;
    if (q_enable[b.q] && !full[b.q]) begin
      exp_wr = 1; exp_addr = (2*lo[b.q] + off[b.q]) / 2; exp_data = b.d;
      wr[b.q]++;
      off[b.q]++;
      if (off[b.q] == 2*(hi[b.q] - lo[b.q])) begin
        if (q_wrap[b.q]) begin off[b.q] = 0; wrapd[b.q] = 1; end
        else full[b.q] = 1;
      end
    end else begin
      dr[b.q]++;
    end
  endtask

  task automatic launch();
    bit avail;
    avail = (hold == 0) && (fq.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
    if (hold > 0) hold--;
    mem_wr_full = (stall > 0) || ($urandom_range(0, 99) < full_pct);
    if (stall > 0) stall--;
    fifo_empty = !avail;
    if (fq.size() > 0) begin fifo_data = fq[0].d; fifo_qid = QB'(fq[0].q); end
    #1;
    chk("fifo_rd_en", fifo_rd_en, avail && !mem_wr_full && cal_done);
    exp_wr = 0;
    if (fifo_rd_en && fq.size() > 0) consume(fq.pop_front());
  endtask

  task automatic tick();
    longint ew, ed;
    @(negedge clk);
    chk("mem_ad_w_n", mem_ad_w_n, !exp_wr);
    chk("mem_d_w_n", mem_d_w_n, !exp_wr);
    if (!mem_ad_w_n) waddr.push_back(int'(mem_ad_wr));
    if (exp_wr) begin
      chk("mem_ad_wr", mem_ad_wr, exp_addr);
      chk("mem_dwl", mem_dwl, exp_data[MDW-1:0]);
      chk("mem_dwh", mem_dwh, exp_data[FDW-1:MDW]);
    end
    if (exp_rst) begin
      chk("rst_ad_wr", mem_ad_wr, 0);
      chk("rst_dwl", mem_dwl, 0);
      chk("rst_dwh", mem_dwh, 0);
      exp_rst = 0;
    end
    chk("mem_bw_n", {mem_bwl_n, mem_bwh_n}, 0);
    for (int i = 0; i < NQ; i++) begin
`ifdef FIFO_TO_MEM_MQ_STATS_EN
      ew = wr[i]; ed = dr[i];
`else
      ew = 0; ed = 0;
`endif
      chk($sformatf("q_full[%0d]", i), q_full[i], full[i]);
      chk($sformatf("q_wrapped[%0d]", i), q_wrapped[i], wrapd[i]);
      chk($sformatf("q_wr_cnt[%0d]", i), q_wr_cnt[i*CW +: CW], ew);
      chk($sformatf("q_drop_cnt[%0d]", i), q_drop_cnt[i*CW +: CW], ed);
    end
  endtask

  task automatic cycle(); launch(); tick(); endtask

  task automatic do_reset();
    rst_n = 0; model_reset(); hold = 2;
    for (int k = 0; k < 2; k++) begin exp_rst = 1; cycle(); end
    rst_n = 1; hold = 3;
  endtask

  task automatic do_swrst();
    sw_rst = 1; cycle();
    sw_rst = 0; model_reset(); hold = 4; exp_rst = 1; cycle();
  endtask

  task automatic push(input int q, input int n);
    for (int k = 0; k < n; k++) fq.push_back('{d: rand_data(), q: q});
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && fq.size() > 0; k++) cycle();
    chk("drain_timeout", fq.size(), 0);
    cycle(); cycle();
  endtask

  initial begin
    int exp40[4] = '{'h100, 'h100, 'h101, 'h101};
    int exp41[6] = '{'h100, 'h100, 'h101, 'h101, 'h100, 'h100};
    int exp43[10] = '{'h200, 'h200, 'h201, 'h201, 'h202, 'h202, 'h203, 'h203, 'h200, 'h200};
    int drops;

    // Region fills without wrap: four writes then two drops
    set_bounds(0, 'h100, 'h102); set_bounds(1, 'h200, 'h204); set_bounds(2, 'h300, 'h302);
    q_enable = 3'b001; q_wrap = 3'b000;
    do_reset();
    waddr.delete(); push(0, 6); drain();
    chk("r40_nwrites", waddr.size(), 4);
    for (int k = 0; k < 4 && k < waddr.size(); k++) chk($sformatf("r40_addr%0d", k), waddr[k], exp40[k]);
    chk("r40_full", q_full[0], 1);
`ifdef FIFO_TO_MEM_MQ_STATS_EN
    drops = 2;
`else
    drops = 0;
`endif
    chk("r40_drops", q_drop_cnt[CW-1:0], drops);

    // Same region in ring mode
    q_wrap = 3'b001;
    do_reset();
    waddr.delete(); push(0, 6); drain();
    chk("r41_nwrites", waddr.size(), 6);
    for (int k = 0; k < 6 && k < waddr.size(); k++) chk($sformatf("r41_addr%0d", k), waddr[k], exp41[k]);
    chk("r41_wrapped", q_wrapped[0], 1);
    chk("r41_full", q_full[0], 0);

    // Interleaved queues keep independent pointers; out-of-range qid is swallowed
    q_enable = 3'b110; q_wrap = 3'b010;
    do_reset();
    waddr.delete(); push(1, 1); push(2, 1); push(1, 1); push(3, 2); drain();
    chk("r42_nwrites", waddr.size(), 3);
    if (waddr.size() == 3) begin
      chk("r42_a0", waddr[0], 'h200); chk("r42_a1", waddr[1], 'h300); chk("r42_a2", waddr[2], 'h200);
    end

    // Back-pressure held for five cycles mid-stream
    do_reset();
    waddr.delete(); push(1, 10);
    for (int k = 0; k < 6; k++) cycle();
    stall = 5;
    drain();
    chk("r43_nwrites", waddr.size(), 10);
    for (int k = 0; k < 10 && k < waddr.size(); k++) chk($sformatf("r43_addr%0d", k), waddr[k], exp43[k]);

    // Software reset mid-stream
    push(1, 8);
    for (int k = 0; k < 5; k++) cycle();
    fq.delete();
    do_swrst();
    cycle(); cycle(); cycle(); cycle();
    chk("r44_cnt", q_wr_cnt, 0);

    // Randomized traffic with enable toggles, calibration loss and one sw reset
    for (int i = 0; i < NQ; i++) set_bounds(i, 'h1000 * (i + 1), 'h1000 * (i + 1) + $urandom_range(1, 3));
    q_wrap = NQ'($urandom_range(0, 7)); q_enable = 3'b111;
    do_reset();
    gap_pct = 20; full_pct = 15;
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (fq.size() < 4) push($urandom_range(0, 3), 1);
      if (r < 3) set_enable(q_enable ^ NQ'(1 << $urandom_range(0, NQ - 1)));
      else if (r < 5 && cal_done) cal_done = 0;
      else if (!cal_done && r < 30) begin cal_done = 1; hold = 3; end
      else if (r == 5 && cal_done && (k % 500) > 300) begin do_swrst(); continue; end
      cycle();
    end
    cal_done = 1; hold = 3; gap_pct = 0; full_pct = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
